pipe_stage_skid: RTL and testbench



---
 rtl/pipe_stage_skid.sv | 91 +++++++++
 tb/tb_pipe_stage_skid.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a valid/ready handshake, an optional 2-entry skid buffer
// and a synchronous flush that turns held entries into bubbles with zeroed control.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 101,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned SKID   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [1:0]        o_occupancy
);

  logic              h_valid_q, h_valid_d;
  logic [DATA_W-1:0] h_data_q, h_data_d;
  logic [CTRL_W-1:0] h_ctrl_q, h_ctrl_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic              accept, drain;

  // With the skid entry, ready depends only on a flop, breaking the backward path.
  assign o_ready = (SKID != 0) ? ~s_valid_q : (~h_valid_q | i_ready);
  assign accept  = i_valid & o_ready;
  assign drain   = h_valid_q & i_ready;

  always_comb begin
    h_valid_d = h_valid_q;
    h_data_d  = h_data_q;
    h_ctrl_d  = h_ctrl_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_ctrl_d  = s_ctrl_q;
    if (i_flush) begin
      h_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (s_valid_q) begin
      // Skid full means o_ready is low, so no accept can coincide with this move.
      if (drain) begin
        h_valid_d = 1'b1;
        h_data_d  = s_data_q;
        h_ctrl_d  = s_ctrl_q;
        s_valid_d = 1'b0;
      end
    end else if (h_valid_q && !drain) begin
      if (accept && (SKID != 0)) begin
        s_valid_d = 1'b1;
        s_data_d  = i_data;
        s_ctrl_d  = i_ctrl;
      end
    end else begin
      h_valid_d = accept;
      if (accept) begin
        h_data_d = i_data;
        h_ctrl_d = i_ctrl;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_valid_q <= 1'b0;
      h_data_q  <= '0;
      h_ctrl_q  <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_ctrl_q  <= '0;
    end else begin
      h_valid_q <= h_valid_d;
      h_data_q  <= h_data_d;
      h_ctrl_q  <= h_ctrl_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_ctrl_q  <= s_ctrl_d;
    end
  end

  assign o_valid     = h_valid_q;
  assign o_data      = h_data_q;
  assign o_ctrl      = h_valid_q ? h_ctrl_q : '0;
  assign o_occupancy = 2'(h_valid_q) + 2'(s_valid_q);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench: dut_a uses the skid buffer, dut_b is the single-entry variant.
module tb_pipe_stage_skid;

  logic       clk = 1'b0;
  logic       rst, flush;
  logic       a_valid, a_ready, a_o_ready, a_o_valid;
  logic [7:0] a_data, a_o_data;
  logic [3:0] a_ctrl, a_o_ctrl;
  logic [1:0] a_occ;
  logic       b_valid, b_ready, b_o_ready, b_o_valid;
  logic [7:0] b_data, b_o_data;
  logic [3:0] b_ctrl, b_o_ctrl;
  logic [1:0] b_occ;

  logic [11:0] qa[$];
  logic [11:0] qb[$];
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(8), .CTRL_W(4), .SKID(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(a_valid), .o_ready(a_o_ready),
    .i_data(a_data), .i_ctrl(a_ctrl), .o_valid(a_o_valid), .i_ready(a_ready),
    .o_data(a_o_data), .o_ctrl(a_o_ctrl), .o_occupancy(a_occ)
  );

  pipe_stage_skid #(.DATA_W(8), .CTRL_W(4), .SKID(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(b_valid), .o_ready(b_o_ready),
    .i_data(b_data), .i_ctrl(b_ctrl), .o_valid(b_o_valid), .i_ready(b_ready),
    .o_data(b_o_data), .o_ctrl(b_o_ctrl), .o_occupancy(b_occ)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every beat handed downstream must match the head of its queue.
  always @(negedge clk) begin
    if (a_o_valid === 1'b1 && a_ready === 1'b1) begin
      if (qa.size() == 0) check("a_unexpected_beat", {a_o_ctrl, a_o_data}, 12'hxxx);
      else check("a_beat", {a_o_ctrl, a_o_data}, qa.pop_front());
    end
    if (b_o_valid === 1'b1 && b_ready === 1'b1) begin
      if (qb.size() == 0) check("b_unexpected_beat", {b_o_ctrl, b_o_data}, 12'hxxx);
      else check("b_beat", {b_o_ctrl, b_o_data}, qb.pop_front());
    end
  end

  // SKID=0 directed table: inputs per cycle and the o_ready/occupancy expected in that cycle.
  logic       tv_vld [6] = '{1, 1, 1, 1, 1, 0};
  logic [7:0] tv_dat [6] = '{8'h10, 8'h11, 8'h11, 8'h12, 8'h12, 8'h00};
  logic       tv_rdy [6] = '{1, 0, 1, 0, 1, 1};
  logic       tv_ordy[6] = '{1, 0, 1, 0, 1, 1};
  logic [1:0] tv_occ [6] = '{0, 1, 1, 1, 1, 1};

  initial begin
    rst = 1'b1; flush = 1'b0;
    a_valid = 0; a_ready = 0; a_data = 0; a_ctrl = 0;
    b_valid = 0; b_ready = 0; b_data = 0; b_ctrl = 0;
    tick(); tick();
    rst = 1'b0;
    // Reset state
    check("a_rst_valid", a_o_valid, 0);
    check("a_rst_ctrl", a_o_ctrl, 0);
    check("a_rst_data", a_o_data, 0);
    check("a_rst_occ", a_occ, 0);
    check("a_rst_ready", a_o_ready, 1);
    check("b_rst_valid", b_o_valid, 0);
    check("b_rst_occ", b_occ, 0);
    check("b_rst_ready", b_o_ready, 1);

    // Streaming 0x1..0x8 with downstream always ready
    a_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      a_valid = 1; a_data = 8'(i); a_ctrl = 4'h5;
      qa.push_back({4'h5, 8'(i)});
      tick();
      check("stream_valid", a_o_valid, 1);
      check("stream_data", a_o_data, i);
      check("stream_occ", a_occ, 1);
      check("stream_ready", a_o_ready, 1);
    end
    a_valid = 0;
    tick();
    check("stream_end_valid", a_o_valid, 0);

    // Backpressure: 0xA to head, 0xB to skid, 0xC held upstream
    a_valid = 1; a_data = 8'hA; a_ctrl = 4'h2; qa.push_back({4'h2, 8'hA});
    tick();
    a_ready = 0; a_data = 8'hB; a_ctrl = 4'h3; qa.push_back({4'h3, 8'hB});
    tick();
    check("bp_occ2", a_occ, 2);
    check("bp_ready_low", a_o_ready, 0);
    check("bp_head", a_o_data, 8'hA);
    a_data = 8'hC; a_ctrl = 4'h4; qa.push_back({4'h4, 8'hC});
    tick();
    check("bp_hold_occ", a_occ, 2);
    check("bp_hold_head", a_o_data, 8'hA);
    a_ready = 1;
    tick();
    check("bp_skid_move", a_o_data, 8'hB);
    check("bp_skid_occ", a_occ, 1);
    check("bp_ready_back", a_o_ready, 1);
    tick();
    check("bp_last", a_o_data, 8'hC);
    check("bp_last_valid", a_o_valid, 1);
    a_valid = 0;
    tick();
    check("bp_drained", a_occ, 0);

    // Flush with both entries full; the beat offered in the flush cycle is dropped
    a_ready = 0; a_valid = 1; a_ctrl = 4'b1011;
    a_data = 8'h21; qa.push_back({4'b1011, 8'h21});
    tick();
    a_data = 8'h22; qa.push_back({4'b1011, 8'h22});
    tick();
    check("fl_pre_occ", a_occ, 2);
    check("fl_pre_ctrl", a_o_ctrl, 4'b1011);
    flush = 1; a_data = 8'hD;
    tick();
    flush = 0; a_valid = 0; qa.delete();
    check("fl_valid", a_o_valid, 0);
    check("fl_ctrl", a_o_ctrl, 0);
    check("fl_occ", a_occ, 0);
    check("fl_ready", a_o_ready, 1);
    a_ready = 1;
    tick(); tick();
    check("fl_no_ghost", a_o_valid, 0);

    // Reset mid-stall, then latency-1 on the first beat after release
    a_ready = 0; a_valid = 1; a_ctrl = 4'h6;
    a_data = 8'h31; tick();
    a_data = 8'h32; tick();
    check("rs_pre_occ", a_occ, 2);
    rst = 1; a_valid = 0;
    tick();
    rst = 0; qa.delete();
    check("rs_valid", a_o_valid, 0);
    check("rs_data", a_o_data, 0);
    check("rs_ctrl", a_o_ctrl, 0);
    check("rs_occ", a_occ, 0);
    check("rs_ready", a_o_ready, 1);
    a_ready = 1; a_valid = 1; a_data = 8'h33; a_ctrl = 4'h7; qa.push_back({4'h7, 8'h33});
    tick();
    a_valid = 0;
    check("rs_first_valid", a_o_valid, 1);
    check("rs_first_data", a_o_data, 8'h33);
    tick();

    // SKID=0: combinational ready under toggling i_ready
    qb.push_back({4'h1, 8'h10});
    qb.push_back({4'h1, 8'h11});
    qb.push_back({4'h1, 8'h12});
    for (int t = 0; t < 6; t++) begin
      b_valid = tv_vld[t]; b_data = tv_dat[t]; b_ctrl = 4'h1; b_ready = tv_rdy[t];
      #1;
      check("b_ready_comb", b_o_ready, tv_ordy[t]);
      check("b_occ", b_occ, tv_occ[t]);
      tick();
    end
    b_valid = 0;
    check("b_end_valid", b_o_valid, 0);
    check("b_end_occ", b_occ, 0);

    // Bubbles: control must read zero while invalid
    a_ctrl = 4'hF; b_ctrl = 4'hF;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bub_a_ctrl", a_o_ctrl, 0);
      check("bub_a_valid", a_o_valid, 0);
      check("bub_b_ctrl", b_o_ctrl, 0);
    end

    tick();
    check("a_queue_empty", qa.size(), 0);
    check("b_queue_empty", qb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
